key_bounce_gen: RTL
===================

# key_bounce_gen

Synthesizable key-press emulator that drives an active-low key line the way a mechanical button does: bounce glitches on press, a clean hold, then bounce on release. It is the stimulus end of the key/debounce path. On-board self-test and simulation benches drive the debouncer's `key` input from it, in place of a physical button. Each `start` request produces one complete, parameterized press/release waveform and a completion pulse.

## Interface
- `N_BOUNCE`, default 3: number of glitch pairs on press and on release. 0 gives clean edges.
- `BOUNCE_CYC`, default 16: length of each glitch segment in clk cycles. Must be ≥ 1.
- `HOLD_CYC`, default 1024: clean low (pressed) duration in clk cycles. Must be ≥ 1.
- `CNT_W`, default 18: segment counter width. Must hold max(`HOLD_CYC`, `BOUNCE_CYC`).

- `clk`, input, 1: system clock.
- `rst`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: request pulse. Sampled on posedge clk.
- `key`, output, 1: emulated key, active low. Idle/released = 1. Registered.
- `busy`, output, 1: high while a press/release sequence is in progress.
- `done`, output, 1: one-cycle pulse marking the end of a sequence.

## Operation
- FSM states: IDLE, PRESS, HOLD, RELEASE.
- A segment counter (CNT_W bits) counts cycles within the current segment.
- A segment index counts 0 … 2·N_BOUNCE−1 within PRESS and within RELEASE.
- IDLE:
  - `key`=1, `busy`=0.
  - `start`=1 → PRESS, or → HOLD directly if N_BOUNCE=0.
- PRESS:
  - 2·N_BOUNCE segments of BOUNCE_CYC cycles each.
  - `key` = 0 on even segments, 1 on odd segments (0,1,0,1,…).
  - After the last segment → HOLD.
- HOLD:
  - `key`=0 for HOLD_CYC cycles.
  - Then → RELEASE, or → IDLE if N_BOUNCE=0.
- RELEASE:
  - 2·N_BOUNCE segments of BOUNCE_CYC cycles each.
  - `key` = 1 on even segments, 0 on odd segments (1,0,1,0,…).
  - After the last segment → IDLE.
- The final `key` transition is always a clean rise into IDLE.
- `done`: high for exactly the first IDLE cycle after HOLD or RELEASE completes. Never high after reset.
- `start` handling:
  - `start` while `busy`=1 is ignored. No queuing.
  - `start` in the `done` cycle is accepted, since `busy`=0 there.
- Reset (`rst`=0), at any time including mid-sequence:
  - All outputs forced immediately (asynchronously) to `key`=1, `busy`=0, `done`=0.
  - State goes to IDLE; counters clear.
  - No `done` is generated for an aborted sequence.
- Counters compare against parameter−1 and reset to 0 at each segment boundary. No wrap-around occurs within valid parameter ranges.

## Timing
- Reset values: `key`=1, `busy`=0, `done`=0.
- Start latency: with `start` sampled high at posedge T, `key`=0 and `busy`=1 take effect from posedge T (visible in cycle T+1).
- Total busy length: `busy`=1 for exactly 4·N_BOUNCE·BOUNCE_CYC + HOLD_CYC cycles.
- With defaults: 192 + 1024 = 1216 cycles.
- `done`, `key` rise and `busy` fall all occur on the same edge.
- Glitch segments are exactly BOUNCE_CYC cycles; there is no jitter.
- Edge count per sequence: 2·N_BOUNCE+1 falling edges and 2·N_BOUNCE+1 rising edges on `key`.

## Test plan
- Reset: assert `rst`=0, release, idle 10 cycles → `key`=1, `busy`=0, `done`=0 throughout.
- Default parameters, one `start` pulse at edge T:
  - `key` toggles every 16 cycles for 6 segments.
  - Then low for 1024 cycles, then 6 release segments.
  - `done` at edge T+1216; 7 falling edges counted.
- N_BOUNCE=0, HOLD_CYC=50, `start` → `key` low for exactly 50 cycles, single fall and single rise, `done` on the rising edge.
- `start` re-pulsed:
  - Mid-HOLD: ignored; sequence length unchanged.
  - In the `done` cycle: accepted; `key` falls on the next edge and a second full sequence runs.
- `rst` pulsed low during HOLD:
  - `key`=1 and `busy`=0 immediately; no `done`.
  - Next `start` reproduces the full-length sequence.
- Loopback into the debouncer (N=1) with HOLD_CYC=300000, CNT_W=19, BOUNCE_CYC=100, three `start` requests → exactly three one-cycle `key_pulse` outputs.

Source files
------------

// File: rtl/key_bounce_gen.sv
// key_bounce_gen: emulates a mechanical push-button on an active-low key line (bounce, clean hold, bounce).
// Latency: key falls and busy rises on the edge that samples start; a sequence lasts 4*N_BOUNCE*BOUNCE_CYC+HOLD_CYC cycles.
// Backpressure: none; start while busy is dropped (no queuing), start during the done cycle begins a new sequence.
module key_bounce_gen #(
  parameter int N_BOUNCE   = 3,     // glitch pairs on press and on release; 0 gives clean edges
  parameter int BOUNCE_CYC = 16,    // cycles per glitch segment, >= 1
  parameter int HOLD_CYC   = 1024,  // clean pressed cycles, >= 1
  parameter int CNT_W      = 18     // must hold max(HOLD_CYC, BOUNCE_CYC)
) (
  input  logic clk,
  input  logic rst,    // asynchronous, active low
  input  logic start,
  output logic key,    // active low, 1 = released
  output logic busy,
  output logic done
);

  // Segments per bounce phase; the index only needs to reach N_SEG-1.
  localparam int N_SEG = 2 * N_BOUNCE;
  localparam int IDX_W = (N_SEG > 1) ? $clog2(N_SEG) : 1;
  localparam bit HAS_BOUNCE = (N_BOUNCE > 0);

  // Terminal counts: segments end when the counter equals length-1.
  localparam logic [CNT_W-1:0] BOUNCE_LAST = CNT_W'(BOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYC - 1);
  localparam logic [IDX_W-1:0] SEG_LAST    = IDX_W'((N_SEG > 0) ? (N_SEG - 1) : 0);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESS   = 2'd1,
    HOLD    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;     // cycle within current segment
  logic [IDX_W-1:0] idx_q, idx_d;     // segment within PRESS / RELEASE
  logic             key_q, key_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             bounce_end;       // last cycle of a glitch segment
  logic             hold_end;         // last cycle of the clean hold
  logic             last_seg;         // current glitch segment is the final one

  assign bounce_end = (cnt_q == BOUNCE_LAST);
  assign hold_end   = (cnt_q == HOLD_LAST);
  assign last_seg   = (idx_q == SEG_LAST);

  // Next-state and next-output logic; outputs are registered so key is glitch-free.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    key_d   = key_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        key_d  = 1'b1;
        busy_d = 1'b0;
        cnt_d  = '0;
        idx_d  = '0;
        if (start) begin
          // First segment of a press (bounce or clean) is always low.
          state_d = HAS_BOUNCE ? PRESS : HOLD;
          key_d   = 1'b0;
          busy_d  = 1'b1;
        end
      end

      PRESS: begin
        // Press pattern: even segments low, odd segments high.
        if (!bounce_end) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          cnt_d = '0;
          if (last_seg) begin
            state_d = HOLD;
            idx_d   = '0;
            key_d   = 1'b0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
            key_d = ~idx_q[0];
          end
        end
      end

      HOLD: begin
        if (!hold_end) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          cnt_d = '0;
          idx_d = '0;
          if (HAS_BOUNCE) begin
            // Release pattern starts with a high segment.
            state_d = RELEASE;
            key_d   = 1'b1;
          end else begin
            state_d = IDLE;
            key_d   = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end

      RELEASE: begin
        // Release pattern: even segments high, odd segments low. N_SEG is even,
        // so the last segment is low and the exit is a clean rise.
        if (!bounce_end) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          cnt_d = '0;
          if (last_seg) begin
            state_d = IDLE;
            idx_d   = '0;
            key_d   = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
            key_d = idx_q[0];
          end
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        idx_d   = '0;
        key_d   = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, counters and output registers; reset forces a released, idle key at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      key_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      key_q   <= key_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign key  = key_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
